ec_point_op_arbiter: RTL and testbench

//   Shares one elliptic-curve point-operation engine (Jacobian add or double, start/done handshake)

---
 rtl/ec_point_op_arbiter_if.sv | 49 ++++
 rtl/ec_point_op_arbiter.sv | 159 +++++++++++++++
 tb/tb_ec_point_op_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ec_point_op_arbiter_if.sv
// Requester-side and engine-side handshake bundle for the EC point-operation arbiter.
// The arbiter connects through the slave modport; the environment (requesters + engine) uses master.
interface ec_point_op_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 256
);
  logic [N_REQ-1:0]   i_req;
  logic [N_REQ-1:0]   i_op;
  logic [N_REQ*W-1:0] i_x1;
  logic [N_REQ*W-1:0] i_y1;
  logic [N_REQ*W-1:0] i_z1;
  logic [N_REQ*W-1:0] i_x2;
  logic [N_REQ*W-1:0] i_y2;
  logic [N_REQ*W-1:0] i_z2;
  logic [W-1:0]       i_p;
  logic [N_REQ-1:0]   o_grant;
  logic [N_REQ-1:0]   o_done;
  logic [W-1:0]       o_x3;
  logic [W-1:0]       o_y3;
  logic [W-1:0]       o_z3;
  logic               o_eng_start;
  logic               o_eng_op;
  logic [W-1:0]       o_eng_x1;
  logic [W-1:0]       o_eng_y1;
  logic [W-1:0]       o_eng_z1;
  logic [W-1:0]       o_eng_x2;
  logic [W-1:0]       o_eng_y2;
  logic [W-1:0]       o_eng_z2;
  logic [W-1:0]       o_eng_p;
  logic               i_eng_done;
  logic [W-1:0]       i_eng_x3;
  logic [W-1:0]       i_eng_y3;
  logic [W-1:0]       i_eng_z3;
  logic               o_err;

  modport slave (
    input  i_req, i_op, i_x1, i_y1, i_z1, i_x2, i_y2, i_z2, i_p,
    input  i_eng_done, i_eng_x3, i_eng_y3, i_eng_z3,
    output o_grant, o_done, o_x3, o_y3, o_z3, o_eng_start, o_eng_op,
    output o_eng_x1, o_eng_y1, o_eng_z1, o_eng_x2, o_eng_y2, o_eng_z2, o_eng_p, o_err
  );

  modport master (
    output i_req, i_op, i_x1, i_y1, i_z1, i_x2, i_y2, i_z2, i_p,
    output i_eng_done, i_eng_x3, i_eng_y3, i_eng_z3,
    input  o_grant, o_done, o_x3, o_y3, o_z3, o_eng_start, o_eng_op,
    input  o_eng_x1, o_eng_y1, o_eng_z1, o_eng_x2, o_eng_y2, o_eng_z2, o_eng_p, o_err
  );
endinterface

// File: rtl/ec_point_op_arbiter.sv
// Round-robin arbiter sharing one EC point-operation engine among N_REQ requesters.
// Optional engine watchdog is enabled by defining ECOP_TIMEOUT_EN.
module ec_point_op_arbiter #(
  parameter int N_REQ       = 4,
  parameter int W           = 256,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                  i_clk,
  input logic                  i_rst,
  ec_point_op_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t           state;
  state_t           next_state;
  logic [IDXW-1:0]  rr_ptr;
  logic [IDXW-1:0]  g;
  logic [IDXW-1:0]  pick;
  logic [IDXW-1:0]  next_ptr;
  logic             pick_valid;
  logic             timeout_hit;
  logic             err;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic             start;
  logic             eng_op;
  logic [W-1:0]     eng_x1, eng_y1, eng_z1, eng_x2, eng_y2, eng_z2;
  logic [W-1:0]     x3, y3, z3;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("ec_point_op_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC positive");
  end

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_valid && bus.i_req[(int'(rr_ptr) + k) % N_REQ]) begin
        pick_valid = 1'b1;
        pick       = IDXW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign next_ptr = (g == IDXW'(N_REQ - 1)) ? '0 : g + IDXW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (pick_valid) next_state = ISSUE;
      ISSUE: next_state = BUSY;
      BUSY: begin
        if (bus.i_eng_done)   next_state = RESP;
        else if (timeout_hit) next_state = IDLE;
      end
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    done  = '0;
    start = 1'b0;
    case (state)
      ISSUE: begin
        grant[g] = 1'b1;
        start    = 1'b1;
      end
      BUSY:  grant[g] = 1'b1;
      RESP: begin
        grant[g] = 1'b1;
        done[g]  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands are frozen at grant so requesters may reuse their input buses during the operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      g      <= '0;
      rr_ptr <= '0;
      eng_op <= 1'b0;
      eng_x1 <= '0;
      eng_y1 <= '0;
      eng_z1 <= '0;
      eng_x2 <= '0;
      eng_y2 <= '0;
      eng_z2 <= '0;
      x3     <= '0;
      y3     <= '0;
      z3     <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        g      <= pick;
        eng_op <= bus.i_op[pick];
        eng_x1 <= bus.i_x1[int'(pick)*W +: W];
        eng_y1 <= bus.i_y1[int'(pick)*W +: W];
        eng_z1 <= bus.i_z1[int'(pick)*W +: W];
        eng_x2 <= bus.i_x2[int'(pick)*W +: W];
        eng_y2 <= bus.i_y2[int'(pick)*W +: W];
        eng_z2 <= bus.i_z2[int'(pick)*W +: W];
      end
      if (state == BUSY && bus.i_eng_done) begin
        x3 <= bus.i_eng_x3;
        y3 <= bus.i_eng_y3;
        z3 <= bus.i_eng_z3;
      end
      if (state == RESP || timeout_hit) rr_ptr <= next_ptr;
    end
  end

`ifdef ECOP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Counter holds zero outside BUSY, so it is already cleared on BUSY entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state == BUSY) ? cnt + CNT_W'(1) : '0;
      err <= timeout_hit;
    end
  end

  assign timeout_hit = (state == BUSY) && !bus.i_eng_done && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign bus.o_grant     = grant;
  assign bus.o_done      = done;
  assign bus.o_eng_start = start;
  assign bus.o_eng_op    = eng_op;
  assign bus.o_eng_x1    = eng_x1;
  assign bus.o_eng_y1    = eng_y1;
  assign bus.o_eng_z1    = eng_z1;
  assign bus.o_eng_x2    = eng_x2;
  assign bus.o_eng_y2    = eng_y2;
  assign bus.o_eng_z2    = eng_z2;
  assign bus.o_eng_p     = bus.i_p;
  assign bus.o_x3        = x3;
  assign bus.o_y3        = y3;
  assign bus.o_z3        = z3;
  assign bus.o_err       = err;
endmodule

// File: tb/tb_ec_point_op_arbiter.sv
// Directed, table-driven bench for ec_point_op_arbiter; the bench plays both requesters and engine.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ec_point_op_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [3:0] req;
    logic [3:0] op;
    int         delay;
    logic [3:0] exp_g;
    logic       exp_op;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[15];

  ec_point_op_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  ec_point_op_arbiter #(.N_REQ(N), .W(W), .TIMEOUT_CYC(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] opnd(input int row, input int r, input int k);
    return {4'(k), 4'(r), 8'(row), 16'h5A00 + 16'(row * 8 + r)};
  endfunction

  function automatic logic [31:0] res(input int row, input int k);
    return {8'hE0 + 8'(k), 8'(row), 16'hBEEF};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %0s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int row);
    for (int r = 0; r < N; r++) begin
      bus.i_x1[r*W +: W] = opnd(row, r, 0);
      bus.i_y1[r*W +: W] = opnd(row, r, 1);
      bus.i_z1[r*W +: W] = opnd(row, r, 2);
      bus.i_x2[r*W +: W] = opnd(row, r, 3);
      bus.i_y2[r*W +: W] = opnd(row, r, 4);
      bus.i_z2[r*W +: W] = opnd(row, r, 5);
    end
  endtask

  task automatic apply_garbage();
    bus.i_x1 = {N{32'hDEADBEEF}};
    bus.i_y1 = {N{32'hDEADBEEF}};
    bus.i_z1 = {N{32'hDEADBEEF}};
    bus.i_x2 = {N{32'hDEADBEEF}};
    bus.i_y2 = {N{32'hDEADBEEF}};
    bus.i_z2 = {N{32'hDEADBEEF}};
  endtask

  task automatic apply_result(input int row);
    bus.i_eng_x3 = res(row, 0);
    bus.i_eng_y3 = res(row, 1);
    bus.i_eng_z3 = res(row, 2);
  endtask

  task automatic check_operands(input string name, input int row, input int g);
    check_output({name, "_x1"}, bus.o_eng_x1, opnd(row, g, 0));
    check_output({name, "_y1"}, bus.o_eng_y1, opnd(row, g, 1));
    check_output({name, "_z1"}, bus.o_eng_z1, opnd(row, g, 2));
    check_output({name, "_x2"}, bus.o_eng_x2, opnd(row, g, 3));
    check_output({name, "_y2"}, bus.o_eng_y2, opnd(row, g, 4));
    check_output({name, "_z2"}, bus.o_eng_z2, opnd(row, g, 5));
  endtask

  task automatic check_result(input string name, input int row);
    check_output({name, "_x3"}, bus.o_x3, res(row, 0));
    check_output({name, "_y3"}, bus.o_y3, res(row, 1));
    check_output({name, "_z3"}, bus.o_z3, res(row, 2));
  endtask

  task automatic check_reset_state(input string name);
    check_output({name, "_grant"}, 32'(bus.o_grant), 32'h0);
    check_output({name, "_done"}, 32'(bus.o_done), 32'h0);
    check_output({name, "_start"}, 32'(bus.o_eng_start), 32'h0);
    check_output({name, "_op"}, 32'(bus.o_eng_op), 32'h0);
    check_output({name, "_err"}, 32'(bus.o_err), 32'h0);
    check_output({name, "_x3"}, bus.o_x3, 32'h0);
    check_output({name, "_y3"}, bus.o_y3, 32'h0);
    check_output({name, "_z3"}, bus.o_z3, 32'h0);
    check_output({name, "_ex1"}, bus.o_eng_x1, 32'h0);
    check_output({name, "_ey1"}, bus.o_eng_y1, 32'h0);
    check_output({name, "_ez1"}, bus.o_eng_z1, 32'h0);
    check_output({name, "_ex2"}, bus.o_eng_x2, 32'h0);
    check_output({name, "_ey2"}, bus.o_eng_y2, 32'h0);
    check_output({name, "_ez2"}, bus.o_eng_z2, 32'h0);
  endtask

  // Full transaction starting at an IDLE falling edge and ending at the following IDLE falling edge.
  task automatic run_op(input int row, input logic [3:0] req, input logic [3:0] op, input int delay,
                        input logic [3:0] exp_g, input logic exp_op);
    int    g;
    string tag;
    g = 0;
    for (int i = 0; i < N; i++) if (exp_g[i]) g = i;
    tag = $sformatf("r%0d", row);
    check_output({tag, "_idle_grant"}, 32'(bus.o_grant), 32'h0);
    check_output({tag, "_idle_done"}, 32'(bus.o_done), 32'h0);
    bus.i_req = req;
    bus.i_op  = op;
    apply_stimulus(row);
    @(negedge clk);
    check_output({tag, "_issue_grant"}, 32'(bus.o_grant), 32'(exp_g));
    check_output({tag, "_issue_start"}, 32'(bus.o_eng_start), 32'h1);
    check_output({tag, "_issue_op"}, 32'(bus.o_eng_op), 32'(exp_op));
    check_operands({tag, "_issue"}, row, g);
    apply_garbage();
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check_output({tag, "_busy_start"}, 32'(bus.o_eng_start), 32'h0);
      check_output({tag, "_busy_done"}, 32'(bus.o_done), 32'h0);
      check_output({tag, "_busy_grant"}, 32'(bus.o_grant), 32'(exp_g));
    end
    check_operands({tag, "_busy"}, row, g);
    bus.i_eng_done = 1'b1;
    apply_result(row);
    @(negedge clk);
    check_output({tag, "_resp_done"}, 32'(bus.o_done), 32'(exp_g));
    check_output({tag, "_resp_grant"}, 32'(bus.o_grant), 32'(exp_g));
    check_result({tag, "_resp"}, row);
    bus.i_eng_done = 1'b0;
    apply_result(99);
    bus.i_req = bus.i_req & ~exp_g;
    @(negedge clk);
    check_output({tag, "_post_grant"}, 32'(bus.o_grant), 32'h0);
    check_output({tag, "_post_done"}, 32'(bus.o_done), 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // rr_ptr evolves across rows: 0 -> 1 -> 3 -> 2 -> 0 -> (fairness run) 0 -> 2 -> 1 -> 0
    vecs[0]  = '{req: 4'b0101, op: 4'b0100, delay: 3,  exp_g: 4'b0001, exp_op: 1'b0};
    vecs[1]  = '{req: 4'b0100, op: 4'b0100, delay: 2,  exp_g: 4'b0100, exp_op: 1'b1};
    vecs[2]  = '{req: 4'b0010, op: 4'b0000, delay: 10, exp_g: 4'b0010, exp_op: 1'b0};
    vecs[3]  = '{req: 4'b1000, op: 4'b1000, delay: 1,  exp_g: 4'b1000, exp_op: 1'b1};
    vecs[4]  = '{req: 4'b1111, op: 4'b1010, delay: 1,  exp_g: 4'b0001, exp_op: 1'b0};
    vecs[5]  = '{req: 4'b1111, op: 4'b1010, delay: 2,  exp_g: 4'b0010, exp_op: 1'b1};
    vecs[6]  = '{req: 4'b1111, op: 4'b1010, delay: 3,  exp_g: 4'b0100, exp_op: 1'b0};
    vecs[7]  = '{req: 4'b1111, op: 4'b1010, delay: 1,  exp_g: 4'b1000, exp_op: 1'b1};
    vecs[8]  = '{req: 4'b1111, op: 4'b1010, delay: 2,  exp_g: 4'b0001, exp_op: 1'b0};
    vecs[9]  = '{req: 4'b1111, op: 4'b1010, delay: 1,  exp_g: 4'b0010, exp_op: 1'b1};
    vecs[10] = '{req: 4'b1111, op: 4'b1010, delay: 4,  exp_g: 4'b0100, exp_op: 1'b0};
    vecs[11] = '{req: 4'b1111, op: 4'b1010, delay: 1,  exp_g: 4'b1000, exp_op: 1'b1};
    vecs[12] = '{req: 4'b1010, op: 4'b0010, delay: 4,  exp_g: 4'b0010, exp_op: 1'b1};
    vecs[13] = '{req: 4'b0001, op: 4'b0001, delay: 2,  exp_g: 4'b0001, exp_op: 1'b1};
    vecs[14] = '{req: 4'b1001, op: 4'b0000, delay: 1,  exp_g: 4'b1000, exp_op: 1'b0};

    rst            = 1'b1;
    bus.i_req      = '0;
    bus.i_op       = '0;
    bus.i_p        = 32'hFFFFFFC5;
    bus.i_eng_done = 1'b0;
    apply_garbage();
    apply_result(99);
    repeat (3) @(negedge clk);
    check_output("eng_p", bus.o_eng_p, 32'hFFFFFFC5);
    rst = 1'b0;
    check_reset_state("reset");

    for (int v = 0; v < 15; v++)
      run_op(v, vecs[v].req, vecs[v].op, vecs[v].delay, vecs[v].exp_g, vecs[v].exp_op);

    // r3 drops its request and reuses its buses mid-operation; stray done in ISSUE is ignored.
    bus.i_req = 4'b1000;
    bus.i_op  = 4'b1000;
    apply_stimulus(30);
    @(negedge clk);
    check_output("t4_issue_grant", 32'(bus.o_grant), 32'h8);
    check_output("t4_issue_op", 32'(bus.o_eng_op), 32'h1);
    bus.i_eng_done = 1'b1;
    apply_result(98);
    @(negedge clk);
    check_output("t4_stray_done", 32'(bus.o_done), 32'h0);
    check_output("t4_busy_grant", 32'(bus.o_grant), 32'h8);
    bus.i_eng_done = 1'b0;
    bus.i_req      = 4'b0001;
    apply_garbage();
    @(negedge clk);
    check_output("t4_other_req_grant", 32'(bus.o_grant), 32'h8);
    check_output("t4_err", 32'(bus.o_err), 32'h0);
    check_operands("t4_busy", 30, 3);
    bus.i_eng_done = 1'b1;
    apply_result(30);
    @(negedge clk);
    check_output("t4_resp_done", 32'(bus.o_done), 32'h8);
    check_result("t4_resp", 30);
    bus.i_eng_done = 1'b0;
    bus.i_req      = 4'b0000;
    @(negedge clk);
    check_output("t4_post_grant", 32'(bus.o_grant), 32'h0);

    // Move rr_ptr to 2 so that a reset which forgets rr_ptr picks a different requester afterwards.
    run_op(31, 4'b0010, 4'b0000, 2, 4'b0010, 1'b0);

    bus.i_req = 4'b0100;
    bus.i_op  = 4'b0000;
    apply_stimulus(32);
    @(negedge clk);
    check_output("t5_issue_grant", 32'(bus.o_grant), 32'h4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    bus.i_req      = 4'b0000;
    bus.i_eng_done = 1'b1;
    apply_result(33);
    check_reset_state("t5_rst");
    @(negedge clk);
    check_output("t5_late_done", 32'(bus.o_done), 32'h0);
    check_output("t5_late_grant", 32'(bus.o_grant), 32'h0);
    check_output("t5_late_x3", bus.o_x3, 32'h0);
    bus.i_eng_done = 1'b0;
    run_op(34, 4'b1010, 4'b1000, 2, 4'b0010, 1'b0);

`ifdef ECOP_TIMEOUT_EN
    bus.i_req = 4'b0011;
    bus.i_op  = 4'b0000;
    apply_stimulus(40);
    @(negedge clk);
    check_output("t6_issue_grant", 32'(bus.o_grant), 32'h1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_output("t6_busy_err", 32'(bus.o_err), 32'h0);
      check_output("t6_busy_done", 32'(bus.o_done), 32'h0);
    end
    @(negedge clk);
    check_output("t6_err", 32'(bus.o_err), 32'h1);
    check_output("t6_err_done", 32'(bus.o_done), 32'h0);
    check_output("t6_err_grant", 32'(bus.o_grant), 32'h0);
    check_result("t6_err_keep", 34);
    @(negedge clk);
    check_output("t6_err_clear", 32'(bus.o_err), 32'h0);
    check_output("t6_next_grant", 32'(bus.o_grant), 32'h2);
    check_output("t6_next_x1", bus.o_eng_x1, opnd(40, 1, 0));
    bus.i_req = 4'b0010;
    repeat (2) @(negedge clk);
    bus.i_eng_done = 1'b1;
    apply_result(41);
    @(negedge clk);
    check_output("t6_next_done", 32'(bus.o_done), 32'h2);
    check_result("t6_next", 41);
    bus.i_eng_done = 1'b0;
    bus.i_req      = 4'b0000;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
